instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction-field encoder feeding a 2-entry output FIFO with a saturating error counter.
// Define ENC_RANGE_CHECK_EN to also flag immediates that cannot be represented exactly in the format.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_I     = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_JALR  = 7'b1100111,
    OP_S     = 7'b0100011,
    OP_B     = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111
  } opcode_e;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        range_bad;

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (in_opcode)
      OP_R:                  enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_I, OP_LOAD, OP_JALR: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_S:                  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_B:                  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                         in_imm[4:1], in_imm[11], in_opcode};
      OP_JAL:                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                         in_rd, in_opcode};
      OP_LUI, OP_AUIPC:      enc_word = {in_imm[31:12], in_rd, in_opcode};
      default:               enc_err  = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Sign-extension check: every bit above the field's top bit must match it.
  always_comb begin
    range_bad = 1'b0;
    case (in_opcode)
      OP_I, OP_LOAD, OP_JALR, OP_S:
        range_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      OP_B:
        range_bad = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
      OP_JAL:
        range_bad = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
      OP_LUI, OP_AUIPC:
        range_bad = |in_imm[11:0];
      default:
        range_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = in_imm[0];
  assign range_bad  = 1'b0;
`endif

  logic [32:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign in_ready  = !rst && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr][31:0] : '0;
  assign out_err   = out_valid ? mem[rd_ptr][32]   : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {enc_err | range_bad, enc_word};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (mem[rd_ptr][32] && (err_cnt != 8'hFF))
          err_cnt <= err_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
